// File: rtl/line_follow_ctrl.sv
// rtl/line_follow_ctrl.sv - line follower steering FSM with sensor debounce and start-up hold
module line_follow_ctrl #(
    parameter int INIT_CYCLES = 80_000_000,
    parameter int DEB_CYCLES  = 50_000,
    parameter int LOST_STEPS  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       l_ir,
    input  logic       r_ir,
    input  logic       step_clk,
    output logic       l_en,
    output logic       r_en,
    output logic [2:0] state,
    output logic       running
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LOST_STEPS + 1);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_FWD     = 3'd1,
        S_STEER_L = 3'd2,
        S_STEER_R = 3'd3,
        S_LOST    = 3'd4,
        S_STOP    = 3'd5
    } state_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Bit 1 is the left sensor, bit 0 the right, so r_filt reads as the (l,r) pair.
    logic [1:0]    r_sync1, r_sync2, r_filt;
    logic [DW-1:0] r_deb_cnt [2];
    logic          r_step_d;
    logic [IW-1:0] r_init_cnt;
    logic [LW-1:0] r_lost_cnt;
    state_t        r_state;
    logic          r_last_dir;
    logic          r_l_en, r_r_en, r_running;

    state_t        w_state_nxt, w_tbl_state;
    logic          w_dir_nxt, w_tbl_dir;
    logic          w_l_en_nxt, w_r_en_nxt;
    logic          w_step_pulse;

    assign w_step_pulse = step_clk & ~r_step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_filt   <= '0;
            r_step_d <= 1'b0;
            for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1  <= {l_ir, r_ir};
            r_sync2  <= r_sync1;
            r_step_d <= step_clk;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_filt[i]    <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_tbl_state = S_LOST;
        w_tbl_dir   = r_last_dir;
        case (r_filt)
            2'b11:   w_tbl_state = S_FWD;
            2'b10: begin
                w_tbl_state = S_STEER_L;
                w_tbl_dir   = DIR_L;
            end
            2'b01: begin
                w_tbl_state = S_STEER_R;
                w_tbl_dir   = DIR_R;
            end
            default: w_tbl_state = S_LOST;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_last_dir;
        case (r_state)
            S_WAIT: begin
                if (r_init_cnt == IW'(INIT_CYCLES - 1)) w_state_nxt = S_FWD;
            end
            S_FWD, S_STEER_L, S_STEER_R: begin
                w_state_nxt = w_tbl_state;
                w_dir_nxt   = w_tbl_dir;
            end
            S_LOST: begin
                // A sensor seeing the line wins over a step pulse arriving on the same cycle.
                if (r_filt != 2'b00) begin
                    w_state_nxt = w_tbl_state;
                    w_dir_nxt   = w_tbl_dir;
                end else if (w_step_pulse && r_lost_cnt == LW'(LOST_STEPS - 1)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_filt != 2'b00) begin
                    w_state_nxt = w_tbl_state;
                    w_dir_nxt   = w_tbl_dir;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase

        w_l_en_nxt = 1'b0;
        w_r_en_nxt = 1'b0;
        case (w_state_nxt)
            S_FWD: begin
                w_l_en_nxt = 1'b1;
                w_r_en_nxt = 1'b1;
            end
            S_STEER_L: w_l_en_nxt = 1'b1;
            S_STEER_R: w_r_en_nxt = 1'b1;
            S_LOST: begin
                w_l_en_nxt = (w_dir_nxt == DIR_L);
                w_r_en_nxt = (w_dir_nxt == DIR_R);
            end
            default: begin
                w_l_en_nxt = 1'b0;
                w_r_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT;
            r_last_dir <= DIR_L;
            r_init_cnt <= '0;
            r_lost_cnt <= '0;
            r_l_en     <= 1'b0;
            r_r_en     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_dir <= w_dir_nxt;
            r_l_en     <= w_l_en_nxt;
            r_r_en     <= w_r_en_nxt;
            if (r_state == S_WAIT && w_state_nxt == S_FWD) r_running <= 1'b1;
            if (r_state == S_WAIT && r_init_cnt != IW'(INIT_CYCLES - 1))
                r_init_cnt <= r_init_cnt + 1'b1;
            if (r_state != S_LOST)
                r_lost_cnt <= '0;
            else if (w_step_pulse && r_lost_cnt != LW'(LOST_STEPS))
                r_lost_cnt <= r_lost_cnt + 1'b1;
        end
    end

    assign l_en    = r_l_en;
    assign r_en    = r_r_en;
    assign state   = r_state;
    assign running = r_running;
endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb/tb_line_follow_ctrl.sv - directed scoreboard bench for line_follow_ctrl
module tb_line_follow_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, l_ir, r_ir, step_clk;
    logic       l_en, r_en, running;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;
    exp_t sb[$];

    line_follow_ctrl #(
        .INIT_CYCLES(100),
        .DEB_CYCLES (4),
        .LOST_STEPS (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .l_ir    (l_ir),
        .r_ir    (r_ir),
        .step_clk(step_clk),
        .l_en    (l_en),
        .r_en    (r_en),
        .state   (state),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic le, input logic re, input logic run);
        exp_t e;
        e.tag = tag;
        e.v   = {st, le, re, run};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [5:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed no expectation, required one queued");
            return;
        end
        e   = sb.pop_front();
        obs = {state, l_en, r_en, running};
        assert (obs === e.v) else begin
            n_errors++;
            $error("FAIL %s: observed state=%0d en=%b%b running=%b required state=%0d en=%b%b running=%b",
                   e.tag, obs[5:3], obs[2], obs[1], obs[0], e.v[5:3], e.v[2], e.v[1], e.v[0]);
        end
    endtask

    task automatic step();
        step_clk = 1'b1;
        tick(1);
        step_clk = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; l_ir = 1'b1; r_ir = 1'b1; step_clk = 1'b0;
        tick(3);
        expect_out("reset_state", 3'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        rst_n = 1'b1;

        // Test 1: start-up hold then forward
        expect_out("wait_99", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(99); check_out();
        expect_out("fwd_after_init", 3'd1, 1'b1, 1'b1, 1'b1);
        tick(1); check_out();

        // Test 2: glitch rejection and exact debounce latency
        r_ir = 1'b0; tick(3); r_ir = 1'b1;
        expect_out("glitch_ignored", 3'd1, 1'b1, 1'b1, 1'b1);
        tick(8); check_out();
        r_ir = 1'b0;
        expect_out("steer_l_at_6", 3'd1, 1'b1, 1'b1, 1'b1);
        tick(6); check_out();
        expect_out("steer_l_at_7", 3'd2, 1'b1, 1'b0, 1'b1);
        tick(1); check_out();

        // Test 3: steer right, lose line, step out to STOP
        l_ir = 1'b0; r_ir = 1'b1;
        expect_out("steer_r_at_6", 3'd2, 1'b1, 1'b0, 1'b1);
        tick(6); check_out();
        expect_out("steer_r_at_7", 3'd3, 1'b0, 1'b1, 1'b1);
        tick(1); check_out();
        r_ir = 1'b0;
        expect_out("lost_dir_r", 3'd4, 1'b0, 1'b1, 1'b1);
        tick(7); check_out();
        step(); step();
        expect_out("lost_after_2", 3'd4, 1'b0, 1'b1, 1'b1);
        check_out();
        step_clk = 1'b1;
        expect_out("stop_after_3", 3'd5, 1'b0, 1'b0, 1'b1);
        tick(1); check_out();
        step_clk = 1'b0; tick(1);

        // Test 5: recover from STOP
        l_ir = 1'b1; r_ir = 1'b1;
        expect_out("stop_hold", 3'd5, 1'b0, 1'b0, 1'b1);
        tick(6); check_out();
        expect_out("stop_to_fwd", 3'd1, 1'b1, 1'b1, 1'b1);
        tick(1); check_out();

        // Test 4: sensor return beats the final step pulse
        l_ir = 1'b0; r_ir = 1'b0;
        expect_out("lost_again", 3'd4, 1'b0, 1'b1, 1'b1);
        tick(7); check_out();
        step(); step();
        expect_out("lost_2_steps", 3'd4, 1'b0, 1'b1, 1'b1);
        check_out();
        r_ir = 1'b1;
        tick(6);
        step_clk = 1'b1;
        expect_out("sensor_beats_step", 3'd3, 1'b0, 1'b1, 1'b1);
        tick(1); check_out();
        step_clk = 1'b0; tick(1);

        // LOST after a left steer drives the left leg
        l_ir = 1'b1; r_ir = 1'b0;
        expect_out("steer_l_again", 3'd2, 1'b1, 1'b0, 1'b1);
        tick(7); check_out();
        l_ir = 1'b0;
        expect_out("lost_dir_l", 3'd4, 1'b1, 1'b0, 1'b1);
        tick(7); check_out();
        l_ir = 1'b1;
        expect_out("lost_to_steer_l", 3'd2, 1'b1, 1'b0, 1'b1);
        tick(7); check_out();

        // Test 6: asynchronous reset mid-operation, full WAIT repeats
        expect_out("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_out();
        tick(2);
        rst_n = 1'b1;
        expect_out("rewait_99", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(99); check_out();
        expect_out("refwd_after_init", 3'd1, 1'b1, 1'b1, 1'b1);
        tick(1); check_out();
        expect_out("steer_l_after_init", 3'd2, 1'b1, 1'b0, 1'b1);
        tick(1); check_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
